// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, addresses the
// synchronous instruction ROM, tags the returning word with its address and
// a valid flag, holds the current instruction across decode stalls and
// redirects on jumps with a single bubble cycle.
module fetch_unit (
   input  logic        clk,
   input  logic        rst_n,
   output logic [9:0]  pc,
   input  logic [15:0] instr,
   input  logic        stall,
   input  logic        jmp_en,
   input  logic [9:0]  jmp_addr,
   output logic [15:0] if_instr,
   output logic [9:0]  if_pc,
   output logic        if_valid,
   output logic [15:0] fetch_count
);

   localparam logic [9:0]  RESET_PC  = 10'd0;
   localparam logic [15:0] NOP_INSTR = 16'h0000;

   // Program counter and the tag of the word the ROM is returning this cycle.
   logic [9:0]  pc_r;
   logic [9:0]  inflight_pc_r;
   logic        inflight_valid_r;

   // One-entry hold register used while decode is stalled.
   logic [15:0] hold_instr_r;
   logic [9:0]  hold_pc_r;
   logic        hold_valid_r;

   logic [15:0] fetch_count_r;

   logic [15:0] out_instr_s;
   logic [9:0]  out_pc_s;
   logic        out_valid_s;
   logic        accept_s;

   // Select what decode sees: held word first, then the ROM word, else a NOP.
   always_comb begin
      out_instr_s = NOP_INSTR;
      out_pc_s    = inflight_pc_r;
      out_valid_s = 1'b0;
      if (hold_valid_r) begin
         out_instr_s = hold_instr_r;
         out_pc_s    = hold_pc_r;
         out_valid_s = 1'b1;
      end else if (inflight_valid_r) begin
         out_instr_s = instr;
         out_pc_s    = inflight_pc_r;
         out_valid_s = 1'b1;
      end else begin
         out_instr_s = NOP_INSTR;
         out_pc_s    = inflight_pc_r;
         out_valid_s = 1'b0;
      end
   end

   // A jump consumes the instruction on the outputs even if decode is stalled.
   always_comb begin
      accept_s = out_valid_s & (jmp_en | ~stall);
   end

   // Fetch pipeline state: jump beats stall, stall beats normal advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r             <= RESET_PC;
         inflight_pc_r    <= RESET_PC;
         inflight_valid_r <= 1'b0;
         hold_instr_r     <= NOP_INSTR;
         hold_pc_r        <= 10'd0;
         hold_valid_r     <= 1'b0;
      end else if (jmp_en) begin
         // The word fetched at the old pc arrives next cycle and is masked.
         pc_r             <= jmp_addr;
         inflight_pc_r    <= pc_r;
         inflight_valid_r <= 1'b0;
         hold_valid_r     <= 1'b0;
      end else if (stall) begin
         // pc does not advance, so the ROM keeps re-reading the next word;
         // the word currently visible is parked in the hold register.
         inflight_pc_r <= pc_r;
         if (!hold_valid_r) begin
            hold_instr_r <= instr;
            hold_pc_r    <= inflight_pc_r;
            hold_valid_r <= inflight_valid_r;
         end else begin
            hold_valid_r <= hold_valid_r;
         end
      end else begin
         pc_r             <= pc_r + 10'd1;
         inflight_pc_r    <= pc_r;
         inflight_valid_r <= 1'b1;
         hold_valid_r     <= 1'b0;
      end
   end

   // Count instructions taken by decode; wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count_r <= 16'd0;
      end else if (accept_s) begin
         fetch_count_r <= fetch_count_r + 16'd1;
      end else begin
         fetch_count_r <= fetch_count_r;
      end
   end

   assign pc          = pc_r;
   assign if_instr    = out_instr_s;
   assign if_pc       = out_pc_s;
   assign if_valid    = out_valid_s;
   assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a synchronous ROM model holding
// ROM[i] = 16'hA000 + i. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [9:0]  pc;
   logic [15:0] instr;
   logic        stall;
   logic        jmp_en;
   logic [9:0]  jmp_addr;
   logic [15:0] if_instr;
   logic [9:0]  if_pc;
   logic        if_valid;
   logic [15:0] fetch_count;

   int checks;
   int failures;

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc),
      .instr       (instr),
      .stall       (stall),
      .jmp_en      (jmp_en),
      .jmp_addr    (jmp_addr),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .if_valid    (if_valid),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data for the address sampled at an edge appears after it.
   always @(posedge clk) begin
      instr <= 16'hA000 + {6'd0, pc};
   end

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; jmp_en = 1'b0; jmp_addr = 10'd0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (pc !== 10'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
      checks++; if (if_instr !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", if_instr); end
      checks++; if (if_pc !== 10'd0) begin failures++; $display("FAIL reset_if_pc got=%0d exp=0", if_pc); end
      checks++; if (fetch_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
      rst_n = 1'b1;
   endtask

   // Ends on the falling edge where if_pc=17.
   task automatic test_free_run();
      for (int i = 0; i <= 17; i++) begin
         @(negedge clk);
         checks++; if (if_valid !== 1'b1 || if_pc !== i[9:0] || if_instr !== (16'hA000 + i[15:0]))
            begin failures++; $display("FAIL run_word i=%0d got v=%b pc=%0d ins=%h", i, if_valid, if_pc, if_instr); end
         checks++; if (fetch_count !== i[15:0]) begin failures++; $display("FAIL run_count got=%0d exp=%0d", fetch_count, i); end
      end
   endtask

   // Starts with if_pc=17 on the outputs; ends on the edge where if_pc=5.
   task automatic test_jump();
      jmp_en = 1'b1; jmp_addr = 10'd3;
      @(negedge clk);
      jmp_en = 1'b0;
      checks++; if (pc !== 10'd3) begin failures++; $display("FAIL jmp_pc got=%0d exp=3", pc); end
      checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0000) begin failures++; $display("FAIL jmp_bubble got v=%b ins=%h exp v=0 ins=0000", if_valid, if_instr); end
      checks++; if (fetch_count !== 16'd18) begin failures++; $display("FAIL jmp_count got=%0d exp=18", fetch_count); end
      for (int i = 3; i <= 5; i++) begin
         @(negedge clk);
         checks++; if (if_valid !== 1'b1 || if_pc !== i[9:0] || if_instr !== (16'hA000 + i[15:0]))
            begin failures++; $display("FAIL jmp_seq exp=%0d got v=%b pc=%0d ins=%h", i, if_valid, if_pc, if_instr); end
      end
      checks++; if (fetch_count !== 16'd20) begin failures++; $display("FAIL jmp_count2 got=%0d exp=20", fetch_count); end
   endtask

   // Starts with if_pc=5; ends on the edge where if_pc=8.
   task automatic test_stall();
      stall = 1'b1;
      checks++; if (pc !== 10'd6) begin failures++; $display("FAIL stall_pc0 got=%0d exp=6", pc); end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         checks++; if (if_valid !== 1'b1 || if_pc !== 10'd5 || if_instr !== 16'hA005)
            begin failures++; $display("FAIL stall_hold j=%0d got v=%b pc=%0d ins=%h exp pc=5 ins=a005", j, if_valid, if_pc, if_instr); end
         checks++; if (pc !== 10'd6) begin failures++; $display("FAIL stall_pc j=%0d got=%0d exp=6", j, pc); end
      end
      stall = 1'b0;
      for (int i = 6; i <= 8; i++) begin
         @(negedge clk);
         checks++; if (if_valid !== 1'b1 || if_pc !== i[9:0] || if_instr !== (16'hA000 + i[15:0]))
            begin failures++; $display("FAIL stall_after exp=%0d got v=%b pc=%0d ins=%h", i, if_valid, if_pc, if_instr); end
      end
      checks++; if (fetch_count !== 16'd23) begin failures++; $display("FAIL stall_count got=%0d exp=23", fetch_count); end
   endtask

   // Starts with if_pc=8; ends on the edge where if_pc=41.
   task automatic test_jump_during_stall();
      stall = 1'b1;
      @(negedge clk);
      checks++; if (if_pc !== 10'd8 || if_instr !== 16'hA008) begin failures++; $display("FAIL jds_hold got pc=%0d ins=%h exp 8 a008", if_pc, if_instr); end
      jmp_en = 1'b1; jmp_addr = 10'd40;
      @(negedge clk);
      jmp_en = 1'b0; stall = 1'b0;
      checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0000 || pc !== 10'd40)
         begin failures++; $display("FAIL jds_bubble got v=%b ins=%h pc=%0d exp 0 0000 40", if_valid, if_instr, pc); end
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc !== 10'd40 || if_instr !== 16'hA028)
         begin failures++; $display("FAIL jds_target got v=%b pc=%0d ins=%h exp 1 40 a028", if_valid, if_pc, if_instr); end
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc !== 10'd41) begin failures++; $display("FAIL jds_next got v=%b pc=%0d exp 1 41", if_valid, if_pc); end
   endtask

   task automatic test_back_to_back();
      jmp_en = 1'b1; jmp_addr = 10'd10;
      @(negedge clk);
      checks++; if (if_valid !== 1'b0 || pc !== 10'd10) begin failures++; $display("FAIL b2b_first got v=%b pc=%0d exp 0 10", if_valid, pc); end
      jmp_addr = 10'd20;
      @(negedge clk);
      jmp_en = 1'b0;
      checks++; if (if_valid !== 1'b0 || pc !== 10'd20) begin failures++; $display("FAIL b2b_second got v=%b pc=%0d exp 0 20", if_valid, pc); end
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc !== 10'd20 || if_instr !== 16'hA014)
         begin failures++; $display("FAIL b2b_target got v=%b pc=%0d ins=%h exp 1 20 a014", if_valid, if_pc, if_instr); end
   endtask

   task automatic test_async_reset();
      jmp_en = 1'b1; jmp_addr = 10'd12;
      @(negedge clk);
      jmp_en = 1'b0;
      @(negedge clk);
      checks++; if (if_pc !== 10'd12 || if_valid !== 1'b1) begin failures++; $display("FAIL ar_setup got pc=%0d v=%b exp 12 1", if_pc, if_valid); end
      stall = 1'b1;
      @(negedge clk);
      checks++; if (if_pc !== 10'd12 || if_instr !== 16'hA00C) begin failures++; $display("FAIL ar_hold got pc=%0d ins=%h exp 12 a00c", if_pc, if_instr); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (pc !== 10'd0 || if_valid !== 1'b0 || if_instr !== 16'h0000 || if_pc !== 10'd0)
         begin failures++; $display("FAIL ar_outputs got pc=%0d v=%b ins=%h ifpc=%0d exp all 0", pc, if_valid, if_instr, if_pc); end
      checks++; if (fetch_count !== 16'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", fetch_count); end
      stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i <= 1; i++) begin
         @(negedge clk);
         checks++; if (if_valid !== 1'b1 || if_pc !== i[9:0] || if_instr !== (16'hA000 + i[15:0]))
            begin failures++; $display("FAIL ar_restart exp=%0d got v=%b pc=%0d ins=%h", i, if_valid, if_pc, if_instr); end
      end
   endtask

   task automatic test_wrap();
      jmp_en = 1'b1; jmp_addr = 10'd1021;
      @(negedge clk);
      jmp_en = 1'b0;
      @(negedge clk);
      checks++; if (if_pc !== 10'd1021 || pc !== 10'd1022) begin failures++; $display("FAIL wrap_start got ifpc=%0d pc=%0d exp 1021 1022", if_pc, pc); end
      @(negedge clk);
      checks++; if (pc !== 10'd1023) begin failures++; $display("FAIL wrap_pc1023 got=%0d exp=1023", pc); end
      @(negedge clk);
      checks++; if (pc !== 10'd0) begin failures++; $display("FAIL wrap_pc0 got=%0d exp=0", pc); end
      checks++; if (if_pc !== 10'd1023 || if_instr !== 16'hA3FF) begin failures++; $display("FAIL wrap_last got pc=%0d ins=%h exp 1023 a3ff", if_pc, if_instr); end
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc !== 10'd0 || if_instr !== 16'hA000)
         begin failures++; $display("FAIL wrap_first got v=%b pc=%0d ins=%h exp 1 0 a000", if_valid, if_pc, if_instr); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_free_run();
      test_jump();
      test_stall();
      test_jump_during_stall();
      test_back_to_back();
      test_async_reset();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
